// File: rtl/lsu_ctrl_if.sv
// Load/store unit bundle: execute-side request, writeback-side response
// and the data RAM port. slave = lsu_ctrl, master = its environment.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_fault;
    logic [1:0]  resp_cause;

    logic        mem_load;
    logic        mem_store;
    logic [2:0]  mem_access;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport slave (
        input  req_valid, req_load, req_store, req_funct3,
        input  req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_data, resp_rd, resp_fault, resp_cause,
        input  resp_ready,
        output mem_load, mem_store, mem_access, mem_addr, mem_data_in,
        input  mem_data_out
    );

    modport master (
        output req_valid, req_load, req_store, req_funct3,
        output req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_data, resp_rd, resp_fault, resp_cause,
        output resp_ready,
        input  mem_load, mem_store, mem_access, mem_addr, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of the data RAM: validate, access, respond.
// Optional macro LSU_MISALIGN_TRAP_EN: fault misaligned H/W accesses.
module lsu_ctrl #(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_BITS   = 13
) (
    input logic       clk,
    input logic       rst,
    lsu_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_MIS   = 2'b01;
    localparam logic [1:0] C_OP    = 2'b10;
    localparam logic [1:0] C_RANGE = 2'b11;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        load_q, load_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    logic        bad_op;
    logic        out_rng;
    logic        misal;
    logic [1:0]  cause;

    // Extract and extend the addressed byte/half from the RAM word.
    // Lanes follow the low address bits the RAM itself ignores.
    function automatic logic [31:0] load_ext(
        input logic [31:0] w,
        input logic [1:0]  a,
        input logic [2:0]  f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'd0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Classify the incoming request; bad op beats range beats alignment.
    always_comb begin
        bad_op = (bus.req_load == bus.req_store);
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: ;
            3'b100, 3'b101: if (bus.req_store) bad_op = 1'b1;
            default: bad_op = 1'b1;
        endcase
        out_rng = (bus.req_addr >> ADDR_BITS) != 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
        misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
             || ((bus.req_funct3[1:0] == 2'b10)
                 && (bus.req_addr[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif
        if (bad_op)       cause = C_OP;
        else if (out_rng) cause = C_RANGE;
        else if (misal)   cause = C_MIS;
        else              cause = C_NONE;
    end

    // Next state, latched request, response and RAM drive.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_d   = load_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        cause_d  = cause_q;

        bus.mem_load    = 1'b0;
        bus.mem_store   = 1'b0;
        bus.mem_access  = 3'd0;
        bus.mem_addr    = 32'd0;
        bus.mem_data_in = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !rst) begin
                    load_d   = bus.req_load;
                    store_d  = bus.req_store;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rd_d     = bus.req_rd;
                    rdata_d  = 32'd0;
                    cause_d  = cause;
                    if (cause != C_NONE) begin
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        fault_d = 1'b0;
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                bus.mem_load    = load_q;
                bus.mem_access  = funct3_q;
                bus.mem_addr    = addr_q;
                bus.mem_data_in = wdata_q;
                if (cnt_q == 4'd0) begin
                    bus.mem_store = store_q && !rst;
                    if (load_q) begin
                        rdata_d = load_ext(bus.mem_data_out,
                                           addr_q[1:0], funct3_q);
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rd_q     <= 5'd0;
            rdata_q  <= 32'd0;
            fault_q  <= 1'b0;
            cause_q  <= C_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE) && !rst;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_data  = rdata_q;
    assign bus.resp_rd    = rd_q;
    assign bus.resp_fault = fault_q;
    assign bus.resp_cause = cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one instance with no wait states and one
// with three, each behind a small word-addressed RAM model.
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;

    always #5 clk = ~clk;

    lsu_ctrl_if if0 ();
    lsu_ctrl_if if3 ();

    lsu_ctrl #(.WAIT_CYCLES(0), .ADDR_BITS(13)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    lsu_ctrl #(.WAIT_CYCLES(3), .ADDR_BITS(13)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    logic        v0 = 1'b0, v3 = 1'b0, rr0 = 1'b0, rr3 = 1'b0;
    logic        r_load = 1'b0, r_store = 1'b0;
    logic [2:0]  r_f3 = 3'd0;
    logic [31:0] r_addr = 32'd0, r_wdata = 32'd0;
    logic [4:0]  r_rd = 5'd0;

    assign if0.req_valid  = v0;
    assign if3.req_valid  = v3;
    assign if0.resp_ready = rr0;
    assign if3.resp_ready = rr3;
    assign if0.req_load   = r_load;
    assign if3.req_load   = r_load;
    assign if0.req_store  = r_store;
    assign if3.req_store  = r_store;
    assign if0.req_funct3 = r_f3;
    assign if3.req_funct3 = r_f3;
    assign if0.req_addr   = r_addr;
    assign if3.req_addr   = r_addr;
    assign if0.req_wdata  = r_wdata;
    assign if3.req_wdata  = r_wdata;
    assign if0.req_rd     = r_rd;
    assign if3.req_rd     = r_rd;

    logic [31:0] ram0 [0:2047];
    logic [31:0] ram3 [0:2047];
    int ld0 = 0, st0 = 0, act0 = 0, st3 = 0;

    assign if0.mem_data_out = ram0[if0.mem_addr[12:2]];
    assign if3.mem_data_out = ram3[if3.mem_addr[12:2]];

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [2:0]  acc,
        input logic [1:0]  a
    );
        logic [31:0] r;
        r = old;
        case (acc[1:0])
            2'b00: begin
                case (a)
                    2'd0:    r[7:0]   = d[7:0];
                    2'd1:    r[15:8]  = d[7:0];
                    2'd2:    r[23:16] = d[7:0];
                    default: r[31:24] = d[7:0];
                endcase
            end
            2'b01: begin
                if (a[1]) r[31:16] = d[15:0];
                else      r[15:0]  = d[15:0];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // RAM model: preload, then write on edges where mem_store is high.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) begin
                ram0[i] <= 32'd0;
                ram3[i] <= 32'd0;
            end
            ram0[0]  <= 32'h12345678;
            ram0[4]  <= 32'hDEADBEEF;
            ram0[12] <= 32'h00800000;
            ram3[16] <= 32'h11111111;
        end else begin
            if (if0.mem_store)
                ram0[if0.mem_addr[12:2]] <= merge(ram0[if0.mem_addr[12:2]],
                    if0.mem_data_in, if0.mem_access, if0.mem_addr[1:0]);
            if (if3.mem_store)
                ram3[if3.mem_addr[12:2]] <= merge(ram3[if3.mem_addr[12:2]],
                    if3.mem_data_in, if3.mem_access, if3.mem_addr[1:0]);
        end
        ld0  <= ld0 + int'(if0.mem_load);
        st0  <= st0 + int'(if0.mem_store);
        st3  <= st3 + int'(if3.mem_store);
        act0 <= act0 + int'(if0.mem_load || if0.mem_store
                || (if0.mem_access != 3'd0) || (if0.mem_addr != 32'd0)
                || (if0.mem_data_in != 32'd0));
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit d3, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         output int lat);
        r_load = ld; r_store = st; r_f3 = f3;
        r_addr = a; r_wdata = wd; r_rd = rd;
        if (d3) v3 = 1'b1; else v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0; v3 = 1'b0;
        lat = 0;
        while (!(d3 ? if3.resp_valid : if0.resp_valid) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack(input bit d3);
        if (d3) rr3 = 1'b1; else rr0 = 1'b1;
        @(negedge clk);
        rr0 = 1'b0; rr3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int b_ld, b_st, b_act;

        repeat (2) @(negedge clk);
        preload = 1'b0;
        @(negedge clk);
        chk("rst_req_ready0", if0.req_ready, 0);
        chk("rst_req_ready3", if3.req_ready, 0);
        chk("rst_resp_valid0", if0.resp_valid, 0);
        chk("rst_resp0", {if0.resp_data[26:0], if0.resp_rd}, 0);
        chk("rst_fault0", {if0.resp_fault, if0.resp_cause}, 0);
        chk("rst_mem0", {if0.mem_load, if0.mem_store, if0.mem_access,
                         if0.mem_addr[26:0]}, 0);
        chk("rst_mem3", {if3.mem_load, if3.mem_store, if3.mem_access,
                         if3.mem_data_in[26:0]}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready0", if0.req_ready, 1);
        chk("idle_req_ready3", if3.req_ready, 1);

        // LW 0x10, no wait states
        b_ld = ld0;
        issue(0, 1, 0, 3'b010, 32'h10, 32'h0, 5'd7, lat);
        chk("lw_latency", lat, 1);
        chk("lw_data", if0.resp_data, 32'hDEADBEEF);
        chk("lw_fault", if0.resp_fault, 0);
        chk("lw_rd", if0.resp_rd, 5'd7);
        chk("lw_req_ready_resp", if0.req_ready, 0);
        chk("lw_load_cycles", ld0 - b_ld, 1);
        ack(0);
        chk("lw_valid_after_ack", if0.resp_valid, 0);
        chk("lw_ready_after_ack", if0.req_ready, 1);

        // SB then byte loads
        b_st = st0;
        issue(0, 0, 1, 3'b000, 32'h21, 32'h000000AB, 5'd3, lat);
        chk("sb_latency", lat, 1);
        chk("sb_data", if0.resp_data, 0);
        chk("sb_fault", if0.resp_fault, 0);
        ack(0);
        chk("sb_store_pulses", st0 - b_st, 1);
        chk("sb_ram", ram0[8], 32'h0000AB00);
        issue(0, 1, 0, 3'b100, 32'h21, 32'h0, 5'd4, lat);
        chk("lbu_data", if0.resp_data, 32'h000000AB);
        ack(0);
        issue(0, 1, 0, 3'b000, 32'h21, 32'h0, 5'd4, lat);
        chk("lb_ab_data", if0.resp_data, 32'hFFFFFFAB);
        ack(0);
        issue(0, 1, 0, 3'b000, 32'h32, 32'h0, 5'd5, lat);
        chk("lb_80_data", if0.resp_data, 32'hFFFFFF80);
        ack(0);
        issue(0, 1, 0, 3'b001, 32'h32, 32'h0, 5'd5, lat);
        chk("lh_hi_data", if0.resp_data, 32'h00000080);
        ack(0);

        // LH at odd address
        b_act = act0;
        b_ld = ld0;
        issue(0, 1, 0, 3'b001, 32'h3, 32'h0, 5'd9, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_latency", lat, 0);
        chk("mis_fault", {if0.resp_fault, if0.resp_cause}, 3'b101);
        chk("mis_data", if0.resp_data, 0);
        chk("mis_mem_activity", act0 - b_act, 0);
`else
        chk("mis_latency", lat, 1);
        chk("mis_fault", {if0.resp_fault, if0.resp_cause}, 3'b000);
        chk("mis_data", if0.resp_data, 32'h00001234);
        chk("mis_load_cycles", ld0 - b_ld, 1);
`endif
        ack(0);

        // Fault causes and priority
        b_act = act0;
        issue(0, 1, 1, 3'b010, 32'h0, 32'h0, 5'd11, lat);
        chk("ldst_latency", lat, 0);
        chk("ldst_fault", {if0.resp_fault, if0.resp_cause}, 3'b110);
        chk("ldst_rd", if0.resp_rd, 5'd11);
        ack(0);
        issue(0, 1, 0, 3'b010, 32'h00002000, 32'h0, 5'd12, lat);
        chk("oor_latency", lat, 0);
        chk("oor_fault", {if0.resp_fault, if0.resp_cause}, 3'b111);
        chk("oor_data", if0.resp_data, 0);
        ack(0);
        issue(0, 0, 1, 3'b100, 32'h00002001, 32'h0, 5'd13, lat);
        chk("sbu_oor_cause", {if0.resp_fault, if0.resp_cause}, 3'b110);
        ack(0);
        issue(0, 0, 0, 3'b010, 32'h4, 32'h0, 5'd14, lat);
        chk("noop_cause", {if0.resp_fault, if0.resp_cause}, 3'b110);
        ack(0);
        issue(0, 0, 1, 3'b010, 32'h00010002, 32'h0, 5'd15, lat);
        chk("oor_beats_mis", {if0.resp_fault, if0.resp_cause}, 3'b111);
        ack(0);
        chk("fault_mem_activity", act0 - b_act, 0);

        // SW with three wait states, stalled response
        b_st = st3;
        r_load = 1'b0; r_store = 1'b1; r_f3 = 3'b010;
        r_addr = 32'h44; r_wdata = 32'hCAFEF00D; r_rd = 5'd20;
        v3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("w3_store_c%0d", c), if3.mem_store,
                (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("w3_addr_c%0d", c), if3.mem_addr, 32'h44);
            chk($sformatf("w3_ready_c%0d", c), if3.req_ready, 0);
            if (c < 4) @(negedge clk);
        end
        chk("w3_data_in", if3.mem_data_in, 32'hCAFEF00D);
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("w3_valid_s%0d", s), if3.resp_valid, 1);
            chk($sformatf("w3_resp_s%0d", s),
                {if3.resp_fault, if3.resp_rd, if3.resp_data[25:0]},
                {1'b0, 5'd20, 26'd0});
            chk($sformatf("w3_ready_s%0d", s), if3.req_ready, 0);
            chk($sformatf("w3_mem_s%0d", s), if3.mem_addr, 0);
            @(negedge clk);
        end
        ack(1);
        chk("w3_ready_idle", if3.req_ready, 1);
        chk("w3_store_pulses", st3 - b_st, 1);
        chk("w3_ram", ram3[17], 32'hCAFEF00D);

        issue(1, 1, 0, 3'b010, 32'h44, 32'h0, 5'd21, lat);
        chk("w3_lw_latency", lat, 4);
        chk("w3_lw_data", if3.resp_data, 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        chk("w3_lw_data_held", if3.resp_data, 32'hCAFEF00D);
        chk("w3_lw_valid_held", if3.resp_valid, 1);
        ack(1);

        // Reset during the final ACCESS cycle of a store
        b_st = st3;
        r_load = 1'b0; r_store = 1'b1; r_f3 = 3'b010;
        r_addr = 32'h40; r_wdata = 32'h00000055; r_rd = 5'd22;
        v3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_store", if3.mem_store, 1);
        rst = 1'b1;
        #1;
        chk("rst_gates_store", if3.mem_store, 0);
        @(negedge clk);
        chk("rst_mid_ready", if3.req_ready, 0);
        chk("rst_mid_valid", if3.resp_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_ready", if3.req_ready, 1);
        chk("rst_after_valid", if3.resp_valid, 0);
        chk("rst_after_mem", if3.mem_addr, 0);
        chk("rst_ram_kept", ram3[16], 32'h11111111);
        chk("rst_no_store", st3 - b_st, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
